// File: rtl/clk_event_pcap_pkg.sv
// Shared types and constants for the clock event packet capture block.
// Entries are kept at a fixed 32-bit timestamp so the package stays unparameterised.
package clks_alot_p;

    localparam int VIOL_W = 11;

    localparam int VIOL_BP_HIGH     = 0;
    localparam int VIOL_BP_LOW      = 1;
    localparam int VIOL_DRIFT_FAST  = 2;
    localparam int VIOL_DRIFT_SLOW  = 3;
    localparam int VIOL_DELTA_RISE  = 4;
    localparam int VIOL_DELTA_FALL  = 5;
    localparam int VIOL_DELTA_PER   = 6;
    localparam int VIOL_DELTA_DUTY  = 7;
    localparam int VIOL_DELTA_PHASE = 8;
    localparam int VIOL_DELTA_JIT   = 9;
    localparam int VIOL_DELTA_LOCK  = 10;

    localparam logic [3:0] PCAP_HDR_MAGIC = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_TS   = 2'd2
    } pcap_state_e;

    typedef struct packed {
        logic              rise;
        logic              fall;
        logic [VIOL_W-1:0] viol;
        logic [31:0]       ts;
    } pcap_entry_t;

endpackage

// File: rtl/clk_event_pcap_fifo.sv
// Single-clock event buffer with registered full/empty flags.
// Full/empty reflect only the previous cycle, so a same-cycle pop never admits a push.
module clk_event_fifo
    import clks_alot_p::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   async_rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  pcap_entry_t            wdata_i,
    output pcap_entry_t            rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    pcap_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q && !flush_i;
    assign do_pop  = pop_i && !empty_q && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
            if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/clk_event_pcap.sv
// Timestamps recovered-clock edges and violation onsets, buffers them and
// streams each one out as a two-beat header/timestamp packet.
module clk_event_pcap
    import clks_alot_p::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              clk_en,
    input  logic              capture_en_i,
    input  logic              clear_i,
    input  logic              clk_rise_i,
    input  logic              clk_fall_i,
    input  logic [VIOL_W-1:0] violation_i,
    input  logic              pcap_ready_i,
    output logic              pcap_valid,
    output logic              pcap_last,
    output logic [31:0]       pcap_data,
    output logic [1:0]        pcap_length_lower
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [14:0]         drop_q, drop_d;
    logic [VIOL_W-1:0]   hist_q, hist_d;
    pcap_state_e         state_q, state_d;

    logic        qual, clr, evt, push, drop;
    logic        xfer, hdr_xfer, ts_xfer;
    logic        full, empty;
    logic [CW-1:0] count;
    pcap_entry_t wr_entry, head;

    assign qual = clk_en && capture_en_i;
    assign clr  = clk_en && clear_i;
    assign evt  = qual && (clk_rise_i || clk_fall_i ||
                           |(violation_i & ~hist_q));
    assign push = evt && !full && !clr;
    assign drop = evt && full && !clr;

    assign xfer     = pcap_valid && pcap_ready_i && clk_en;
    assign hdr_xfer = xfer && (state_q == ST_HDR) && !clr;
    assign ts_xfer  = xfer && (state_q == ST_TS) && !clr;

    assign wr_entry = '{rise: clk_rise_i, fall: clk_fall_i,
                        viol: violation_i, ts: 32'(ts_q)};

    clk_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .async_rst(async_rst),
        .flush_i  (clr),
        .push_i   (push),
        .pop_i    (ts_xfer),
        .wdata_i  (wr_entry),
        .rdata_o  (head),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count)
    );

    always_comb begin
        ts_d    = ts_q;
        hist_d  = hist_q;
        drop_d  = drop_q;
        state_d = state_q;
        if (qual) begin
            ts_d   = ts_q + TS_WIDTH'(1);
            hist_d = violation_i;
        end
        // A drop landing on the header beat survives as a count of one.
        if (hdr_xfer) drop_d = '0;
        if (drop && drop_d != 15'h7FFF) drop_d = drop_d + 15'd1;
        unique case (state_q)
            ST_IDLE: if (clk_en && !empty) state_d = ST_HDR;
            ST_HDR:  if (xfer) state_d = ST_TS;
            ST_TS:   if (xfer) state_d = (count > CW'(1) || push) ? ST_HDR : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            ts_d    = '0;
            drop_d  = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            ts_q    <= '0;
            drop_q  <= '0;
            hist_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            ts_q    <= ts_d;
            drop_q  <= drop_d;
            hist_q  <= hist_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        pcap_data = '0;
        unique case (1'b1)
            state_q == ST_HDR: pcap_data = {PCAP_HDR_MAGIC, head.rise, head.fall,
                                            head.viol, drop_q};
            state_q == ST_TS:  pcap_data = head.ts;
            default: ;
        endcase
    end

    assign pcap_valid        = (state_q != ST_IDLE);
    assign pcap_last         = (state_q == ST_TS);
    assign pcap_length_lower = 2'b00;

endmodule

// File: tb/tb_clk_event_pcap.sv
// Bench for clk_event_pcap: scenario tasks plus randomized traffic
// against a queue-based packet model.
module tb_clk_event_pcap;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        async_rst;
    logic        clk_en;
    logic        capture_en_i;
    logic        clear_i;
    logic        clk_rise_i;
    logic        clk_fall_i;
    logic [10:0] violation_i;
    logic        pcap_ready_i;
    logic        pcap_valid;
    logic        pcap_last;
    logic [31:0] pcap_data;
    logic [1:0]  pcap_length_lower;

    clk_event_pcap #(
        .FIFO_DEPTH(DEPTH),
        .TS_WIDTH  (32)
    ) dut (
        .clk              (clk),
        .async_rst        (async_rst),
        .clk_en           (clk_en),
        .capture_en_i     (capture_en_i),
        .clear_i          (clear_i),
        .clk_rise_i       (clk_rise_i),
        .clk_fall_i       (clk_fall_i),
        .violation_i      (violation_i),
        .pcap_ready_i     (pcap_ready_i),
        .pcap_valid       (pcap_valid),
        .pcap_last        (pcap_last),
        .pcap_data        (pcap_data),
        .pcap_length_lower(pcap_length_lower)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        f;
        logic [10:0] v;
        logic [31:0] ts;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_ts;
    logic [14:0] m_drop;
    logic [10:0] m_hist;
    bit          m_phase;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic        gotl_q[$];
    logic        expl_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        gotl_q.delete();
        expl_q.delete();
    endtask

    task automatic quiet_inputs();
        clk_en       = 1'b1;
        capture_en_i = 1'b1;
        clear_i      = 1'b0;
        clk_rise_i   = 1'b0;
        clk_fall_i   = 1'b0;
        violation_i  = '0;
        pcap_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        async_rst    = 1'b1;
        quiet_inputs();
        capture_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 async_rst = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        m_ts    = '0;
        m_drop  = '0;
        m_hist  = '0;
        m_phase = 1'b0;
        clear_logs();
        quiet_inputs();
    endtask

    // One clock of the packet model; logs every DUT transfer and what the model wanted.
    task automatic step();
        bit    qual, clr, xfer, evt, was_full;
        ment_t e;
        qual = clk_en && capture_en_i;
        clr  = clk_en && clear_i;
        xfer = pcap_valid && pcap_ready_i && clk_en;
        evt  = qual && (clk_rise_i || clk_fall_i ||
                        ((violation_i & ~m_hist) != 11'd0));
        if (clr) begin
            mq.delete();
            m_ts    = '0;
            m_drop  = '0;
            m_phase = 1'b0;
        end else begin
            was_full = (mq.size() >= DEPTH);
            if (xfer) begin
                got_q.push_back(pcap_data);
                gotl_q.push_back(pcap_last);
                if (mq.size() == 0) begin
                    exp_q.push_back('x);
                    expl_q.push_back(1'bx);
                end else if (!m_phase) begin
                    exp_q.push_back({4'hA, mq[0].r, mq[0].f, mq[0].v, m_drop});
                    expl_q.push_back(1'b0);
                    m_phase = 1'b1;
                    m_drop  = '0;
                end else begin
                    exp_q.push_back(mq[0].ts);
                    expl_q.push_back(1'b1);
                    m_phase = 1'b0;
                    void'(mq.pop_front());
                end
            end
            if (evt) begin
                if (was_full) begin
                    if (m_drop != 15'h7FFF) m_drop = m_drop + 15'd1;
                end else begin
                    e.r  = clk_rise_i;
                    e.f  = clk_fall_i;
                    e.v  = violation_i;
                    e.ts = m_ts;
                    mq.push_back(e);
                end
            end
            if (qual) m_ts = m_ts + 32'd1;
        end
        if (qual) m_hist = violation_i;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (mq.size() == 0 && !pcap_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (mq.size() == 0 && !pcap_valid) ok = 1'b1;
    endtask

    task automatic test_reset();
        async_rst = 1'b1;
        quiet_inputs();
        #1;
        n_checks++;
        if (pcap_valid !== 1'b0 || pcap_last !== 1'b0 ||
            pcap_data !== 32'd0 || pcap_length_lower !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h len=%b, want all 0",
                     pcap_valid, pcap_last, pcap_data, pcap_length_lower);
        end
        do_reset();
        n_checks++;
        if (pcap_valid !== 1'b0 || pcap_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b d=%h, want 0", pcap_valid, pcap_data);
        end
    endtask

    task automatic test_single_rise();
        bit ok;
        do_reset();
        pcap_ready_i = 1'b1;
        repeat (5) step();
        clk_rise_i = 1'b1;
        step();
        clk_rise_i = 1'b0;
        n_checks++;
        if (pcap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: valid=%b one cycle after event, want 0", pcap_valid);
        end
        step();
        n_checks++;
        if (pcap_valid !== 1'b1 || pcap_length_lower !== 2'b00) begin
            n_fail++;
            $display("FAIL latency_2: valid=%b len=%b, want 1/00", pcap_valid, pcap_length_lower);
        end
        drain(20, ok);
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL single_count: ok=%0d words=%0d, want 1/2", ok, got_q.size());
        end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[0] !== 32'hA800_0000 || gotl_q[0] !== 1'b0 ||
                got_q[1] !== 32'h0000_0005 || gotl_q[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL single_words: got %h/%b %h/%b, want a8000000/0 00000005/1",
                         got_q[0], gotl_q[0], got_q[1], gotl_q[1]);
            end
        end
    endtask

    task automatic test_merge();
        bit ok;
        do_reset();
        pcap_ready_i = 1'b1;
        repeat (3) step();
        clk_rise_i  = 1'b1;
        violation_i = 11'b000_0000_1000;
        step();
        clk_rise_i = 1'b0;
        repeat (3) step();
        violation_i = '0;
        drain(20, ok);
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL merge_count: ok=%0d words=%0d, want 1/2", ok, got_q.size());
        end
        if (got_q.size() >= 1) begin
            n_checks++;
            if (got_q[0] !== 32'hA804_0000) begin
                n_fail++;
                $display("FAIL merge_hdr: got %h, want a8040000", got_q[0]);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== expl_q[i]) begin
                n_fail++;
                $display("FAIL merge_word%0d: got %h/%b, want %h/%b",
                         i, got_q[i], gotl_q[i], exp_q[i], expl_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            clk_rise_i = 1'b1;
            clk_fall_i = i[0];
            step();
        end
        clk_rise_i = 1'b0;
        clk_fall_i = 1'b0;
        repeat (3) step();
        pcap_ready_i = 1'b1;
        drain(4 * DEPTH + 20, ok);
        n_checks++;
        if (!ok || got_q.size() != 2 * DEPTH) begin
            n_fail++;
            $display("FAIL ovf_count: ok=%0d words=%0d, want 1/%0d", ok, got_q.size(), 2 * DEPTH);
        end
        if (got_q.size() >= 1) begin
            n_checks++;
            if (got_q[0][14:0] !== 15'd3) begin
                n_fail++;
                $display("FAIL ovf_drop: got %0d, want 3", got_q[0][14:0]);
            end
        end
        if (got_q.size() >= 3) begin
            n_checks++;
            if (got_q[2][14:0] !== 15'd0) begin
                n_fail++;
                $display("FAIL ovf_drop_clr: got %0d, want 0", got_q[2][14:0]);
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== expl_q[i]) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got %h/%b, want %h/%b",
                         i, got_q[i], gotl_q[i], exp_q[i], expl_q[i]);
            end
        end
    endtask

    task automatic test_ready_toggle();
        bit          ok, stall, held_l;
        logic [31:0] held_d;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            pcap_ready_i = c[0];
            clk_rise_i   = (c < 6) && !c[0];
            clk_fall_i   = (c < 6) && c[0];
            stall  = pcap_valid && !pcap_ready_i;
            held_d = pcap_data;
            held_l = pcap_last;
            step();
            if (stall) begin
                n_checks++;
                if (pcap_valid !== 1'b1 || pcap_data !== held_d || pcap_last !== held_l) begin
                    n_fail++;
                    $display("FAIL toggle_hold: got %b/%h/%b, want 1/%h/%b",
                             pcap_valid, pcap_data, pcap_last, held_d, held_l);
                end
            end
        end
        pcap_ready_i = 1'b1;
        drain(40, ok);
        n_checks++;
        if (!ok || got_q.size() != 12) begin
            n_fail++;
            $display("FAIL toggle_count: ok=%0d words=%0d, want 1/12", ok, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== expl_q[i]) begin
                n_fail++;
                $display("FAIL toggle_word%0d: got %h/%b, want %h/%b",
                         i, got_q[i], gotl_q[i], exp_q[i], expl_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        do_reset();
        repeat (4) step();
        clk_rise_i = 1'b1;
        step();
        clk_rise_i = 1'b0;
        clk_fall_i = 1'b1;
        step();
        clk_fall_i = 1'b0;
        for (int i = 0; i < 10 && !pcap_valid; i++) step();
        pcap_ready_i = 1'b1;
        step();
        pcap_ready_i = 1'b0;
        n_checks++;
        if (pcap_valid !== 1'b1 || pcap_last !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_in_ts: got v=%b l=%b, want 1/1", pcap_valid, pcap_last);
        end
        clear_i      = 1'b1;
        pcap_ready_i = 1'b1;
        clk_rise_i   = 1'b1;
        step();
        clear_i    = 1'b0;
        clk_rise_i = 1'b0;
        n_checks++;
        if (pcap_valid !== 1'b0 || pcap_data !== 32'd0) begin
            n_fail++;
            $display("FAIL clear_valid: got v=%b d=%h, want 0/0", pcap_valid, pcap_data);
        end
        clear_logs();
        clk_fall_i = 1'b1;
        step();
        clk_fall_i = 1'b0;
        drain(20, ok);
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL clear_flush: ok=%0d words=%0d, want 1/2", ok, got_q.size());
        end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[0] !== 32'hA400_0000 || got_q[1] !== 32'd0) begin
                n_fail++;
                $display("FAIL clear_ts: got %h %h, want a4000000 00000000", got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        pcap_ready_i = 1'b1;
        clk_rise_i   = 1'b1;
        step();
        clk_rise_i = 1'b0;
        clk_fall_i = 1'b1;
        step();
        clk_fall_i = 1'b0;
        for (int i = 0; i < 10 && got_q.size() == 0; i++) step();
        pcap_ready_i = 1'b0;
        n_checks++;
        if (pcap_last !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_mid: got last=%b, want 1", pcap_last);
        end
        #2 async_rst = 1'b1;
        #1;
        n_checks++;
        if (pcap_valid !== 1'b0 || pcap_last !== 1'b0 ||
            pcap_data !== 32'd0 || pcap_length_lower !== 2'd0) begin
            n_fail++;
            $display("FAIL arst_now: got v=%b l=%b d=%h, want 0", pcap_valid, pcap_last, pcap_data);
        end
        do_reset();
        pcap_ready_i = 1'b1;
        repeat (8) step();
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL arst_trunc: got %0d words, want 0", got_q.size());
        end
        violation_i = 11'h400;
        step();
        violation_i = '0;
        drain(20, ok);
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL arst_after: ok=%0d words=%0d, want 1/2", ok, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== expl_q[i]) begin
                n_fail++;
                $display("FAIL arst_word%0d: got %h/%b, want %h/%b",
                         i, got_q[i], gotl_q[i], exp_q[i], expl_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int b;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            clk_en       = ($urandom_range(0, 9) != 0);
            capture_en_i = ($urandom_range(0, 7) != 0);
            clear_i      = ($urandom_range(0, 199) == 0);
            clk_rise_i   = ($urandom_range(0, 4) == 0);
            clk_fall_i   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, 10);
                violation_i[b] = ~violation_i[b];
            end
            if (((c / 100) % 2) == 1) pcap_ready_i = ($urandom_range(0, 7) == 0);
            else pcap_ready_i = ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (pcap_length_lower !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_len: got %b, want 00", pcap_length_lower);
            end
        end
        quiet_inputs();
        pcap_ready_i = 1'b1;
        drain(200, ok);
        n_checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: ok=%0d got=%0d want=%0d", ok, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== expl_q[i]) begin
                n_fail++;
                $display("FAIL rand_word%0d: got %h/%b, want %h/%b",
                         i, got_q[i], gotl_q[i], exp_q[i], expl_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_merge();
        test_overflow();
        test_ready_toggle();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
